// File: rtl/fetch_buffer_dual.sv
// Two-wide circular instruction FIFO between fetch and decode: 0..2 pushes and 0..2 pops per cycle.
// Optional statistics outputs (full_cycles, high_water) are built when FETCH_BUFFER_STATS_EN is defined.
module fetch_buffer_dual #(
    parameter int DATA_WIDTH        = 64,
    parameter int DEPTH             = 8,
    parameter int EARLY_FULL_MARGIN = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                push_cnt,
    input  logic [2*DATA_WIDTH-1:0]   data_in,
    input  logic [1:0]                pop_cnt,
    output logic [DATA_WIDTH-1:0]     data_out0,
    output logic [DATA_WIDTH-1:0]     data_out1,
    output logic [1:0]                out_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      early_full,
    output logic                      overflow,
    output logic                      underflow
`ifdef FETCH_BUFFER_STATS_EN
    ,
    output logic [31:0]               full_cycles,
    output logic [$clog2(DEPTH):0]    high_water
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] EF_LEVEL = CW'(DEPTH - EARLY_FULL_MARGIN);

    logic [DATA_WIDTH-1:0] storage [DEPTH];

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] wr_idx1;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rd_idx1;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic [CW-1:0] space;
    logic          full_q;
    logic          early_full_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          push_ok;
    logic          pop_ok;
    logic [1:0]    push_acc;
    logic [1:0]    pop_acc;

    // Push legality sees only pre-pop space, pop legality only pre-push occupancy,
    // so the fetch and decode sides never depend on each other combinationally.
    always_comb begin
        space      = DEPTH_C - count_q;
        push_ok    = (push_cnt != 2'd3) && (CW'(push_cnt) <= space);
        pop_ok     = (pop_cnt != 2'd3) && (CW'(pop_cnt) <= count_q);
        push_acc   = push_ok ? push_cnt : 2'd0;
        pop_acc    = pop_ok ? pop_cnt : 2'd0;
        count_next = count_q + CW'(push_acc) - CW'(pop_acc);
    end

    assign wr_idx1 = wr_idx + AW'(1);
    assign rd_idx1 = rd_idx + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx       <= '0;
            rd_idx       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            early_full_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (flush) begin
            wr_idx       <= '0;
            rd_idx       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            early_full_q <= 1'b0;
        end else begin
            wr_idx       <= wr_idx + AW'(push_acc);
            rd_idx       <= rd_idx + AW'(pop_acc);
            count_q      <= count_next;
            full_q       <= (count_next == DEPTH_C);
            early_full_q <= (count_next >= EF_LEVEL);
            if (!push_ok) begin
                overflow_q <= 1'b1;
            end
            if (!pop_ok) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; a rejected push writes nothing at all.
    always_ff @(posedge clk) begin
        if (!rst && !flush && (push_acc != 2'd0)) begin
            storage[wr_idx] <= data_in[DATA_WIDTH-1:0];
            if (push_acc == 2'd2) begin
                storage[wr_idx1] <= data_in[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    assign data_out0  = storage[rd_idx];
    assign data_out1  = storage[rd_idx1];
    assign out_valid  = {count_q >= CW'(2), count_q != '0};
    assign count      = count_q;
    assign full       = full_q;
    assign early_full = early_full_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef FETCH_BUFFER_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0]   full_cycles_q;
    logic [CW-1:0] high_water_q;

    // Statistics survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_cycles_q <= '0;
            high_water_q  <= '0;
        end else begin
            if (full_q) begin
                full_cycles_q <= sat_inc32(full_cycles_q);
            end
            if (!flush && (count_next > high_water_q)) begin
                high_water_q <= count_next;
            end
        end
    end

    assign full_cycles = full_cycles_q;
    assign high_water  = high_water_q;
`endif

endmodule

// File: tb/tb_fetch_buffer_dual.sv
// Randomised scoreboard bench for fetch_buffer_dual against a queue-based reference model.
module tb_fetch_buffer_dual;

    localparam int DW     = 64;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [1:0]        push_cnt = 2'd0;
    logic [2*DW-1:0]   data_in = '0;
    logic [1:0]        pop_cnt = 2'd0;
    logic [DW-1:0]     data_out0;
    logic [DW-1:0]     data_out1;
    logic [1:0]        out_valid;
    logic [CW-1:0]     count;
    logic              full;
    logic              early_full;
    logic              overflow;
    logic              underflow;
`ifdef FETCH_BUFFER_STATS_EN
    logic [31:0]       full_cycles;
    logic [CW-1:0]     high_water;
`endif

    fetch_buffer_dual #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .EARLY_FULL_MARGIN(MARGIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push_cnt(push_cnt),
        .data_in(data_in),
        .pop_cnt(pop_cnt),
        .data_out0(data_out0),
        .data_out1(data_out1),
        .out_valid(out_valid),
        .count(count),
        .full(full),
        .early_full(early_full),
        .overflow(overflow),
        .underflow(underflow)
`ifdef FETCH_BUFFER_STATS_EN
        ,
        .full_cycles(full_cycles),
        .high_water(high_water)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        ovf;
        logic        unf;
        logic [31:0] fc;
        int          hw;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [31:0] m_fc = '0;
    int          m_hw = 0;
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act === want) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // One stimulus cycle: drive, advance the reference model, queue the expected post-edge state.
    task automatic step(input logic r, input logic f, input logic [1:0] pc, input logic [1:0] pp);
        logic [63:0] l0;
        logic [63:0] l1;
        int          pre;
        exp_t        e;
        l0 = {$urandom, $urandom};
        l1 = {$urandom, $urandom};
        @(negedge clk);
        rst      = r;
        flush    = f;
        push_cnt = pc;
        pop_cnt  = pp;
        data_in  = {l1, l0};
        pre = mq.size();
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_fc  = '0;
            m_hw  = 0;
        end else begin
            if (pre == DEPTH && m_fc != 32'hffff_ffff) m_fc = m_fc + 32'd1;
            if (f) begin
                mq.delete();
            end else begin
                if (pp <= 2 && int'(pp) <= pre) begin
                    repeat (int'(pp)) void'(mq.pop_front());
                end else begin
                    m_unf = 1'b1;
                end
                if (pc <= 2 && int'(pc) <= DEPTH - pre) begin
                    if (pc >= 1) mq.push_back(l0);
                    if (pc == 2) mq.push_back(l1);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (mq.size() > m_hw) m_hw = mq.size();
        end
        e.cnt = mq.size();
        e.d0  = (mq.size() >= 1) ? mq[0] : 64'd0;
        e.d1  = (mq.size() >= 2) ? mq[1] : 64'd0;
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.fc  = m_fc;
        e.hw  = m_hw;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new state after every edge; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", 64'(count), 64'(e.cnt));
                chk("out_valid", 64'(out_valid), {62'd0, e.cnt >= 2, e.cnt >= 1});
                chk("full", 64'(full), 64'(e.cnt == DEPTH));
                chk("early_full", 64'(early_full), 64'(e.cnt >= DEPTH - MARGIN));
                chk("overflow", 64'(overflow), 64'(e.ovf));
                chk("underflow", 64'(underflow), 64'(e.unf));
                if (e.cnt >= 1) chk("data_out0", data_out0, e.d0);
                if (e.cnt >= 2) chk("data_out1", data_out1, e.d1);
`ifdef FETCH_BUFFER_STATS_EN
                chk("full_cycles", 64'(full_cycles), 64'(e.fc));
                chk("high_water", 64'(high_water), 64'(e.hw));
`endif
            end
        end
    end

    initial begin
        logic [1:0] pc;
        logic [1:0] pp;
        logic       fill_phase;
        // Reset, then idle
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // Push two, pop one at a time
        step(0, 0, 2, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        // Fill, then push+pop at full
        for (int i = 0; i < 4; i++) step(0, 0, 2, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        // Wrap across index 7 -> 0
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 2, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 2, 0);
        step(0, 0, 2, 2);
        step(0, 0, 2, 2);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        // Empty: push accepted, pop rejected
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        // Flush at count 5 with a push in the same cycle
        step(0, 0, 2, 0);
        step(0, 0, 2, 0);
        step(0, 0, 1, 0);
        step(0, 1, 2, 0);
        step(0, 0, 0, 0);
        // Randomised traffic, alternating fill-biased and drain-biased phases
        fill_phase = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) fill_phase = ~fill_phase;
            if ($urandom_range(0, 99) < 3) pc = 2'd3;
            else if (fill_phase) pc = 2'($urandom_range(1, 2));
            else pc = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) pp = 2'd3;
            else if (fill_phase) pp = 2'($urandom_range(0, 1));
            else pp = 2'($urandom_range(1, 2));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0, pc, pp);
        end
        step(0, 0, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
